shared_buffer_arbiter: RTL and testbench

//  Shares the single-port 64x512b shared_buffer SRAM between NUM_REQ requesters.

---
 rtl/shared_buffer_arbiter.sv | 84 ++++++++
 tb/tb_shared_buffer_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_buffer_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters.
// One access per cycle; read data comes back as a registered one-hot pulse two cycles after grant.
module shared_buffer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 6,
  parameter int DW      = 512,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  CEN,
  output logic                  WEN,
  output logic [AW-1:0]         A,
  output logic [DW-1:0]         D,
  output logic                  RETN,
  input  logic [DW-1:0]         Q
);

  localparam logic [NUM_REQ-1:0] ONEHOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [IDW-1:0]     r_ptr;
  logic [NUM_REQ-1:0] r_rd_vld_p1;
  logic [NUM_REQ-1:0] r_rsp_vld_p2;
  logic [DW-1:0]      r_rsp_data_p2;

  logic               w_found;
  logic [IDW-1:0]     w_win;
  int                 w_idx;
  logic               w_gnt;
  logic [NUM_REQ-1:0] w_gnt_oh;

  // Stage p0: pick the first valid requester at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  // Reset blanks the grant combinationally so the SRAM is never touched while RST is high.
  assign w_gnt    = w_found & ~RST;
  assign w_gnt_oh = w_gnt ? (ONEHOT0 << w_win) : '0;

  assign req_ready = w_gnt_oh;
  assign CEN       = ~w_gnt;
  assign WEN       = ~(w_gnt & req_we[w_win]);
  assign A         = w_gnt ? req_addr[w_win*AW +: AW]  : '0;
  assign D         = w_gnt ? req_wdata[w_win*DW +: DW] : '0;
  assign RETN      = ~RST;

  // Stage p1: remember who owns the read in flight; Stage p2: capture Q with its owner.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr         <= '0;
      r_rd_vld_p1   <= '0;
      r_rsp_vld_p2  <= '0;
      r_rsp_data_p2 <= '0;
    end else begin
      if (w_gnt) r_ptr <= (int'(w_win) == NUM_REQ-1) ? '0 : w_win + 1'b1;
      r_rd_vld_p1  <= (w_gnt && !req_we[w_win]) ? w_gnt_oh : '0;
      r_rsp_vld_p2 <= r_rd_vld_p1;
      // Q is zeroed by the SRAM when idle, so only capture on a real read.
      if (|r_rd_vld_p1) r_rsp_data_p2 <= Q;
    end
  end

  assign rsp_valid = r_rsp_vld_p2;
  assign rsp_data  = r_rsp_data_p2;

endmodule

// File: tb/tb_shared_buffer_arbiter.sv
// Bench for shared_buffer_arbiter: SRAM model, reference memory and a response scoreboard.
module tb_shared_buffer_arbiter;

  localparam int NR = 4;
  localparam int AW = 6;
  localparam int DW = 512;

  logic              CLK;
  logic              RST;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              CEN, WEN, RETN;
  logic [AW-1:0]     A;
  logic [DW-1:0]     D;
  logic [DW-1:0]     Q;

  shared_buffer_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .CEN(CEN), .WEN(WEN),
    .A(A), .D(D), .RETN(RETN), .Q(Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_rsp3 = 0;

  logic [DW-1:0] sram      [64];
  logic [DW-1:0] model_mem [64];

  typedef struct {
    logic [NR-1:0] vld;
    logic [DW-1:0] data;
    int            cyc;
  } sb_t;
  sb_t sb[$];
  sb_t e;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      sram[i]      = '0;
      model_mem[i] = '0;
    end
  end

  // SRAM model: Q valid the cycle after a read, zero when idle.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!CEN && !WEN) sram[A] <= D;
    if (!CEN && WEN) Q <= sram[A];
    else             Q <= '0;
  end

  // Monitor: response scoreboard, handshake recording, pin checks.
  always @(negedge CLK) begin
    int w;
    if (rsp_valid == 4'b1000) n_rsp3 = n_rsp3 + 1;
    if (rsp_valid != '0) begin
      if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, '0);
      else begin
        e = sb.pop_front();
        chk("rsp_vld", rsp_valid, e.vld);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_lat", cyc, e.cyc);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      chk("rsp_missing", rsp_valid, sb[0].vld);
      void'(sb.pop_front());
    end
    if (RST === 1'b1) sb.delete();
    chk("rdy_onehot", ($countones(req_ready) <= 1), 1'b1);
    chk("rdy_subset", req_ready & ~req_valid, '0);
    chk("retn", RETN, !RST);
    w = -1;
    for (int i = NR-1; i >= 0; i--) if (req_valid[i] && req_ready[i]) w = i;
    if (w >= 0) begin
      chk("acc_cen", CEN, 1'b0);
      chk("acc_wen", WEN, !req_we[w]);
      chk("acc_addr", A, req_addr[w*AW +: AW]);
      if (req_we[w]) begin
        chk("acc_d", D, req_wdata[w*DW +: DW]);
        model_mem[req_addr[w*AW +: AW]] = req_wdata[w*DW +: DW];
      end else begin
        e.vld  = 4'b0001 << w;
        e.data = model_mem[req_addr[w*AW +: AW]];
        e.cyc  = cyc + 2;
        sb.push_back(e);
      end
    end else begin
      chk("idle_cen", CEN, 1'b1);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]            = 1'b1;
    req_we[i]               = we;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NR-1:0] exp_gnt [6];
    logic [AW-1:0] a;
    int base;
    RST = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    idle();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i), '0);
    step();
    step();
    @(negedge CLK);
    chk("rst_ready", req_ready, '0);
    chk("rst_cen", CEN, 1'b1);
    chk("rst_wen", WEN, 1'b1);
    chk("rst_a", A, '0);
    chk("rst_retn", RETN, 1'b0);

    // Reset release with nothing requested
    step(); idle(); RST = 1'b0;
    @(negedge CLK);
    chk("t1_cen", CEN, 1'b1);
    chk("t1_wen", WEN, 1'b1);
    chk("t1_ready", req_ready, '0);
    chk("t1_rsp_valid", rsp_valid, '0);
    chk("t1_rsp_data", rsp_data, '0);
    chk("t1_retn", RETN, 1'b1);

    // Write then read-after-write by another requester
    step(); idle(); set_req(1, 1'b1, 6'd5, {64{8'hA5}});
    @(negedge CLK); chk("t2_wr_ready", req_ready, 4'b0010);
    step(); idle(); set_req(2, 1'b0, 6'd5, '0);
    @(negedge CLK); chk("t2_rd_ready", req_ready, 4'b0100);
    step(); idle();
    step();
    @(negedge CLK);
    chk("t2_rsp_valid", rsp_valid, 4'b0100);
    chk("t2_rsp_data", rsp_data, {64{8'hA5}});

    // Round-robin continues from the last winner
    step(); idle(); set_req(2, 1'b0, 6'd5, '0);
    @(negedge CLK); chk("t4_ready_a", req_ready, 4'b0100);
    step(); idle(); set_req(0, 1'b0, 6'd1, '0); set_req(3, 1'b0, 6'd5, '0);
    @(negedge CLK); chk("t4_ready_b", req_ready, 4'b1000);
    step();
    @(negedge CLK); chk("t4_ready_c", req_ready, 4'b0001);
    step(); idle();

    // All requesters valid from reset
    step(); RST = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i + 4), '0);
    step(); RST = 1'b0;
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int g = 0; g < 6; g++) begin
      @(negedge CLK);
      chk($sformatf("t3_gnt%0d", g), req_ready, exp_gnt[g]);
      if (g < 5) step();
    end
    step(); idle();
    repeat (3) step();

    // Reset while a read is in flight
    step(); idle(); set_req(0, 1'b0, 6'd5, '0);
    @(negedge CLK); chk("t5_ready", req_ready, 4'b0001);
    step(); idle(); RST = 1'b1;
    @(negedge CLK);
    chk("t5_rst_ready", req_ready, '0);
    chk("t5_rst_cen", CEN, 1'b1);
    step(); RST = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i), '0);
    @(negedge CLK);
    chk("t5_no_rsp", rsp_valid, '0);
    chk("t5_rsp_data", rsp_data, '0);
    chk("t5_ptr0", req_ready, 4'b0001);
    step(); idle();
    repeat (3) step();

    // Lone requester: fill memory, then stream reads with address wrap
    a = '0;
    for (int k = 0; k < 64; k++) begin
      step(); idle(); set_req(3, 1'b1, a, rnd());
      @(negedge CLK); chk("t6_wr_ready", req_ready, 4'b1000);
      a = a + 1'b1;
    end
    step(); idle();
    step();
    base = n_rsp3;
    for (int k = 0; k < 65; k++) begin
      step(); idle(); set_req(3, 1'b0, a, '0);
      @(negedge CLK); chk("t6_rd_ready", req_ready, 4'b1000);
      a = a + 1'b1;
    end
    step(); idle();
    repeat (4) step();
    @(negedge CLK);
    chk("t6_rsp_count", n_rsp3 - base, 65);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
